// File: rtl/rr_arbiter16.sv
// Round-robin arbiter: 16 requesters share one N-bit valid/ready output channel.
// Arbitration happens in IDLE, and the granted word is held in BUSY until it is accepted.

module rr_mux4 #(
   parameter int W = 32
) (
   input  logic [3:0][W-1:0] d_in,
   input  logic [1:0]        sel,
   output logic [W-1:0]      d_out
);
   assign d_out = d_in[sel];
endmodule

module rr_arbiter16 #(
   parameter int N = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       req,
   input  logic [16*N-1:0]   data_in,
   output logic [15:0]       ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_data,
   output logic [3:0]        select
);
   typedef enum logic {IDLE, BUSY} state_e;

   state_e            state_q, state_d;
   logic [3:0]        select_q, select_d;
   logic [3:0]        ptr_q, ptr_d;
   logic [3:0]        winner;
   logic [3:0]        idx;
   logic              found;

   // The scan starts at ptr+1 and ends at ptr itself (k=16 wraps to offset 0).
   // As a result, the last-served requester has the lowest priority.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= 16; k++) begin
         idx = ptr_q + 4'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      ptr_d    = ptr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               select_d = winner;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            // The req bit is not checked again here: a grant stays in force until it is accepted.
            if (out_ready) begin
               ptr_d   = select_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         select_q <= '0;
         ptr_q    <= 4'hF;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         ptr_q    <= ptr_d;
      end
   end

   // A grant that is in flight when rst is applied is dropped without an ack.
   assign out_valid = (state_q == BUSY) && !rst;
   assign ack       = (out_valid && out_ready) ? (16'h0001 << select_q) : 16'h0000;
   assign select    = select_q;

   logic [15:0][N-1:0] data_arr;
   logic [3:0][N-1:0]  lvl1;
   logic [3:0]         sel_eff;

   assign data_arr = data_in;
   assign sel_eff  = rst ? 4'd0 : select_q;

   for (genvar g = 0; g < 4; g++) begin : g_lvl1
      rr_mux4 #(.W(N)) u_mux (
         .d_in  (data_arr[4*g +: 4]),
         .sel   (sel_eff[1:0]),
         .d_out (lvl1[g])
      );
   end

   rr_mux4 #(.W(N)) u_mux_lvl2 (
      .d_in  (lvl1),
      .sel   (sel_eff[3:2]),
      .d_out (out_data)
   );
endmodule

// File: tb/tb_rr_arbiter16.sv
// Scoreboard bench for rr_arbiter16: each stimulus step queues the transfers it expects,
// and a negedge monitor checks every accepted word along with its ack and its spacing.

module tb_rr_arbiter16;
   localparam int N = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       req;
   logic [16*N-1:0]   data_in;
   logic [15:0]       ack;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      out_data;
   logic [3:0]        select;

   logic [N-1:0]      slice_v [16];

   typedef struct {
      logic [3:0]   sel;
      logic [N-1:0] data;
      logic [15:0]  ack;
      int           gap;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_xfer = 0;

   rr_arbiter16 #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .select    (select)
   );

   always #5 clk = ~clk;

   always_comb begin
      data_in = '0;
      for (int i = 0; i < 16; i++) data_in[i*N +: N] = slice_v[i];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int idx, input int gap);
      exp_t e;
      e.sel  = idx[3:0];
      e.data = slice_v[idx];
      e.ack  = 16'h0001 << idx;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input int maxc, input string name);
      int n = 0;
      while (sb.size() != 0 && n < maxc) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d transfers still pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // monitor: compares every accepted word against the head of the scoreboard
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: select=%0d ack=%h, required no transfer", select, ack);
         end else begin
            m_e = sb.pop_front();
            chk("xfer_select", 64'(select), 64'(m_e.sel));
            chk("xfer_data", 64'(out_data), 64'(m_e.data));
            chk("xfer_ack", 64'(ack), 64'(m_e.ack));
            if (m_e.gap > 0) chk("xfer_gap", 64'(cyc - last_xfer), 64'(m_e.gap));
         end
         last_xfer = cyc;
      end else begin
         chk("no_xfer_ack", 64'(ack), 64'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req       = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) slice_v[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0011;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_ack", 64'(ack), 64'h0);
      chk("rst_data", 64'(out_data), 64'(slice_v[0]));
      chk("rst_select", 64'(select), 64'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 64'(out_valid), 64'h0);
      chk("post_rst_data", 64'(out_data), 64'(slice_v[0]));

      // two requesters at opposite ends of the ring: 0,15,0,15,...
      @(posedge clk); #1;
      req = 16'h8001; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) push((k % 2) ? 15 : 0, (k == 0) ? 0 : 2);
      wait_drain(40, "alt_8001");

      // all requesting: a full rotation that wraps back to 0
      req = 16'hFFFF;
      for (int k = 0; k < 17; k++) push(k % 16, (k == 0) ? 0 : 2);
      wait_drain(80, "all_ffff");
      req = '0;

      // single requester stalled for 5 cycles, then accepted
      slice_v[4] = 32'hDEADBEEF;
      req = 16'h0010; out_ready = 1'b0;
      push(4, 0);
      @(posedge clk);
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", 64'(out_valid), 64'h1);
         chk("stall_data", 64'(out_data), 64'hDEADBEEF);
         chk("stall_select", 64'(select), 64'h4);
         @(posedge clk);
      end
      #1 out_ready = 1'b1;
      wait_drain(4, "stall");
      req = '0;
      @(negedge clk);
      chk("stall_done_valid", 64'(out_valid), 64'h0);

      // req dropped while busy does not cancel the grant
      @(posedge clk); #1;
      req = 16'h0080; out_ready = 1'b0;
      push(7, 0);
      @(posedge clk);
      #1 req = '0;
      repeat (3) begin
         @(negedge clk);
         chk("drop_valid", 64'(out_valid), 64'h1);
         chk("drop_select", 64'(select), 64'h7);
         @(posedge clk);
      end
      #1 out_ready = 1'b1;
      wait_drain(4, "drop");

      // ptr=7, req {7,2}: 2 wins first, then the requesters alternate
      req = 16'h0084;
      push(2, 0); push(7, 2); push(2, 2); push(7, 2);
      wait_drain(20, "last_prio");
      req = '0;

      // reset applied in BUSY with out_ready high: no ack, and ptr returns to 15
      @(posedge clk); #1;
      req = 16'h0020; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rb_busy_valid", 64'(out_valid), 64'h1);
      chk("rb_busy_select", 64'(select), 64'h5);
      @(posedge clk); #1;
      rst = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("rb_ack", 64'(ack), 64'h0);
      chk("rb_valid", 64'(out_valid), 64'h0);
      chk("rb_data", 64'(out_data), 64'(slice_v[0]));
      @(posedge clk); #1;
      rst = 1'b0; req = '0;
      @(negedge clk);
      chk("rb_after_valid", 64'(out_valid), 64'h0);
      chk("rb_after_select", 64'(select), 64'h0);
      @(posedge clk); #1;
      req = 16'h8001;
      push(0, 0);
      wait_drain(6, "rb_ptr");
      req = '0;

      // long idle: no output, and select holds
      repeat (10) begin
         @(negedge clk);
         chk("idle_valid", 64'(out_valid), 64'h0);
         chk("idle_select", 64'(select), 64'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001: Parameter N, default 32, gives the width of each requester data word and of out_data.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high, sampled on the clk rising edge.
REQ-004: req  input  16  per-requester request; bit i = requester i has a word pending.
REQ-005: data_in  input  16*N  packed requester data; requester i occupies bits [i*N+N-1 : i*N].
REQ-006: ack  output  16  one-hot; bit i high for exactly the cycle requester i's word is accepted.
REQ-007: out_valid  output  1  out_data holds a granted word.
REQ-008: out_ready  input  1  downstream accepts out_data this cycle when out_valid is also high.
REQ-009: out_data  output  N  data of the currently granted requester.
REQ-010: select  output  4  index of the currently granted requester (registered).

Function
REQ-011: The block SHALL share one N-bit output channel among 16 requesters, with a two-state FSM {IDLE, BUSY}.
REQ-012: out_data SHALL equal the data_in slice selected by select, via a 16:1 N-bit mux tree of 4:1 stages (select[1:0] first level, select[3:2] second level).
REQ-013: ptr (4-bit register) SHALL hold the index of the most recently served requester.
REQ-014: IDLE: out_valid=0, ack=0; if req!=0, the winner SHALL be the first set req bit scanning ptr+1, ptr+2, ... wrapping mod 16 through ptr itself; select<=winner, state<=BUSY.
REQ-015: IDLE with req==0: state, select and ptr SHALL hold.
REQ-016: BUSY: out_valid=1; out_data and select SHALL be stable until acceptance.
REQ-017: BUSY with out_ready=1: ack[select]=1 combinationally that cycle, ptr<=select, state<=IDLE.
REQ-018: BUSY with out_ready=0: state, select, ptr SHALL hold; ack=0.
REQ-019: Throughput SHALL be one word per two cycles minimum (grant cycle in IDLE, transfer in BUSY); arbitration-to-out_valid latency is 1 cycle.
REQ-020: Requesters SHALL hold req and data stable until their ack; the block SHALL NOT re-check req[select] in BUSY (a dropped req does not cancel the grant).
REQ-021: A requester whose req stays high after ack SHALL be considered last in priority at the next arbitration (winner only if no other req set).
REQ-022: Wrap-around: with ptr=15 the scan SHALL start at index 0.
REQ-023: At most one ack bit SHALL ever be high; ack SHALL be zero whenever out_valid=0.

Reset
REQ-024: When rst=1 at a clk edge: state<=IDLE, select<=0, ptr<=15, so the first arbitration after reset favors requester 0.
REQ-025: During and the cycle after reset: out_valid=0, ack=0; out_data = data_in slice 0.
REQ-026: Reset asserted in BUSY SHALL abandon the grant without issuing ack, regardless of out_ready.

Verification
REQ-027: After reset, req=16'h8001, out_ready=1 continuously -> grants in order 0,15,0,15,...; ack=16'h0001 then 16'h8000 alternating, each on BUSY cycles two cycles apart.
REQ-028: req=16'hFFFF held, out_ready=1 -> select sequence 0,1,2,...,15,0 (wrap), each requester acked once per 32 cycles.
REQ-029: Single req=16'h0010 with data_in slice 4=32'hDEADBEEF, out_ready=0 for 5 cycles then 1 -> out_valid high 6 cycles, out_data=32'hDEADBEEF stable, ack=16'h0010 only on final cycle.
REQ-030: req bit 7 dropped while BUSY on 7 with out_ready=0 -> out_valid stays 1, select stays 7; ack[7] issued when out_ready rises.
REQ-031: rst asserted in BUSY with out_ready=1 -> no ack, next cycle out_valid=0, select=0, ptr=15.
REQ-032: req=0 for 10 cycles -> out_valid=0, ack=0, select unchanged throughout.
